// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory load stage: load-op encodings, the load
// state machine type and bus-width helpers derived from PC_W/DEST_W.
package mem_stage_pkg;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // PASS is the transient WAIT+data_ok cycle; it never persists in the register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_PASS  = 2'd3
  } ld_state_e;

  function automatic int es2ms_bus_w(input int pc_w, input int dest_w);
    return pc_w + 32 + 4 + dest_w + 1;
  endfunction

  function automatic int ms2ws_bus_w(input int pc_w, input int dest_w);
    return pc_w + 1 + dest_w + 32;
  endfunction

endpackage

// File: rtl/mem_ld_stage_if.sv
// EX->MEM and MEM->WB handshake bundle; master is the surrounding pipeline,
// slave is the memory stage.
interface mem_ld_stage_if
  import mem_stage_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int DEST_W = 5
) ();

  logic                                   es2ms_valid;
  logic                                   ms_allowin;
  logic [es2ms_bus_w(PC_W, DEST_W)-1:0]   es2ms_bus;
  logic                                   ws_allowin;
  logic                                   ms2ws_valid;
  logic [ms2ws_bus_w(PC_W, DEST_W)-1:0]   ms2ws_bus;

  modport master (
    output es2ms_valid, es2ms_bus, ws_allowin,
    input  ms_allowin, ms2ws_valid, ms2ws_bus
  );

  modport slave (
    input  es2ms_valid, es2ms_bus, ws_allowin,
    output ms_allowin, ms2ws_valid, ms2ws_bus
  );

endinterface

// File: rtl/load_align.sv
// Combinational byte/half selection and extension of returned load data.
// Misaligned half/word offsets are treated as aligned down.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  ld_op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (ld_op)
      LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    result = {{16{half_sel[15]}}, half_sel};
      LD_BU:   result = {24'h0, byte_sel};
      LD_HU:   result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_ld_stage.sv
// Memory stage: holds one instruction, waits for load data, aligns it and
// hands the result to WB; returns belonging to flushed loads are discarded.
module mem_ld_stage
  import mem_stage_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int DEST_W = 5,
  parameter int DISC_W = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 es2ms_valid,
  output logic                                 ms_allowin,
  input  logic [es2ms_bus_w(PC_W, DEST_W)-1:0] es2ms_bus,
  input  logic                                 data_sram_data_ok,
  input  logic [31:0]                          data_sram_rdata,
  input  logic                                 ms_flush,
  input  logic                                 ws_allowin,
  output logic                                 ms2ws_valid,
  output logic [ms2ws_bus_w(PC_W, DEST_W)-1:0] ms2ws_bus,
  output logic                                 mem_rf_we,
  output logic [DEST_W-1:0]                    mem_dest,
  output logic [31:0]                          final_result,
  output logic                                 ms_ld_wait
);

  logic [PC_W-1:0]   in_pc;
  logic [31:0]       in_alu;
  logic              in_mreq;
  logic [2:0]        in_ldop;
  logic [DEST_W-1:0] in_dest;
  logic              in_gr_we;

  assign {in_pc, in_alu, in_mreq, in_ldop, in_dest, in_gr_we} = es2ms_bus;

  logic [PC_W-1:0]   pc_q;
  logic [31:0]       alu_q;
  logic              mreq_q;
  logic [2:0]        ldop_q;
  logic [DEST_W-1:0] dest_q;
  logic              grwe_q;
  logic              valid_q, valid_d;
  ld_state_e         state_q, state_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  logic [31:0]       hold_q, hold_d;

  logic        dok, ready_go, accept, disc_inc, disc_dec;
  logic [31:0] ld_result;

  // A return is ours only once every flushed request has been drained.
  assign dok         = data_sram_data_ok && (disc_q == '0);
  assign ready_go    = !mreq_q || (state_q == ST_HOLD) || (state_q == ST_WAIT && dok);
  assign ms_allowin  = !valid_q || (ready_go && ws_allowin);
  assign ms2ws_valid = valid_q && ready_go;
  assign accept      = es2ms_valid && ms_allowin && !ms_flush;
  assign ms_ld_wait  = valid_q && mreq_q && (state_q == ST_WAIT) && !dok;
  assign disc_inc    = ms_flush && valid_q && mreq_q && (state_q == ST_WAIT) && !dok;
  assign disc_dec    = data_sram_data_ok && (disc_q != '0);

  always_comb begin
    valid_d = valid_q;
    state_d = state_q;
    hold_d  = hold_q;
    disc_d  = disc_q;
    if (ms_allowin) begin
      valid_d = es2ms_valid;
      state_d = (es2ms_valid && in_mreq) ? ST_WAIT : ST_EMPTY;
    end else if (valid_q && state_q == ST_WAIT && dok) begin
      state_d = ST_HOLD;
      hold_d  = data_sram_rdata;
    end
    if (ms_flush) begin
      valid_d = 1'b0;
      state_d = ST_EMPTY;
    end
    if (disc_inc && !disc_dec && disc_q != '1) begin
      disc_d = disc_q + DISC_W'(1);
    end else if (disc_dec && !disc_inc) begin
      disc_d = disc_q - DISC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      state_q <= ST_EMPTY;
      disc_q  <= '0;
      hold_q  <= '0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
      disc_q  <= disc_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q   <= in_pc;
      alu_q  <= in_alu;
      mreq_q <= in_mreq;
      ldop_q <= in_ldop;
      dest_q <= in_dest;
      grwe_q <= in_gr_we;
    end
  end

  load_align u_load_align (
    .rdata  ((state_q == ST_HOLD) ? hold_q : data_sram_rdata),
    .offset (alu_q[1:0]),
    .ld_op  (ldop_q),
    .result (ld_result)
  );

  assign final_result = mreq_q ? ld_result : alu_q;
  assign mem_rf_we    = valid_q && grwe_q;
  assign mem_dest     = dest_q;
  assign ms2ws_bus    = {pc_q, grwe_q, dest_q, final_result};

endmodule

// File: tb/tb_mem_ld_stage.sv
// Randomized and directed bench for mem_ld_stage against a request-ordered
// memory model: each return belongs to the oldest outstanding request.
module tb_mem_ld_stage;
  import mem_stage_pkg::*;

  localparam int PC_W   = 32;
  localparam int DEST_W = 5;
  localparam int DISC_W = 2;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [31:0]       alu;
    logic              mreq;
    logic [2:0]        op;
    logic [DEST_W-1:0] dest;
    logic              we;
    int                tag;
  } ins_t;

  typedef struct {
    int tag;
    int issued;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  logic data_ok, ms_flush, mem_rf_we, ms_ld_wait;
  logic [31:0] rdata, final_result;
  logic [DEST_W-1:0] mem_dest;

  mem_ld_stage_if #(.PC_W(PC_W), .DEST_W(DEST_W)) bus ();

  mem_ld_stage #(.PC_W(PC_W), .DEST_W(DEST_W), .DISC_W(DISC_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .es2ms_valid       (bus.es2ms_valid),
    .ms_allowin        (bus.ms_allowin),
    .es2ms_bus         (bus.es2ms_bus),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .ms_flush          (ms_flush),
    .ws_allowin        (bus.ws_allowin),
    .ms2ws_valid       (bus.ms2ws_valid),
    .ms2ws_bus         (bus.ms2ws_bus),
    .mem_rf_we         (mem_rf_we),
    .mem_dest          (mem_dest),
    .final_result      (final_result),
    .ms_ld_wait        (ms_ld_wait)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  ins_t occ;
  bit   occ_v, occ_held;
  logic [31:0] occ_data;
  req_t memq[$];
  int   cyc = 0;
  int   next_tag = 0;

  // stimulus for the next step
  bit   es_v, ws, fl, dok;
  ins_t es_ins;
  logic [31:0] rd;

  // observations from the DUT
  int obs_cnt, obs_wait;
  logic [31:0] obs_last;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] op);
    logic [31:0] b, h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
    case (op)
      3'd1:    return b[7] ? (b | 32'hFFFFFF00) : b;
      3'd2:    return h[15] ? (h | 32'hFFFF0000) : h;
      3'd3:    return b;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  function automatic ins_t mk(input bit mreq, input logic [2:0] op, input logic [31:0] alu);
    ins_t i;
    i.pc   = $urandom;
    i.alu  = alu;
    i.mreq = mreq;
    i.op   = op;
    i.dest = DEST_W'($urandom);
    i.we   = 1'b1;
    i.tag  = 0;
    return i;
  endfunction

  task automatic idle_in();
    es_v = 0; ws = 1; fl = 0; dok = 0; rd = $urandom;
    es_ins = mk(1'b0, 3'd0, 32'h0);
  endtask

  task automatic clear_obs();
    obs_cnt = 0; obs_wait = 0; obs_last = '0;
  endtask

  // one clock: drive, compare against the model, advance both
  task automatic step();
    bit got, ready, allowin;
    logic [31:0] data, exp_res;
    bus.es2ms_valid = es_v;
    bus.es2ms_bus   = {es_ins.pc, es_ins.alu, es_ins.mreq, es_ins.op, es_ins.dest, es_ins.we};
    bus.ws_allowin  = ws;
    ms_flush        = fl;
    data_ok         = dok;
    rdata           = rd;
    #1;
    got     = occ_held || (dok && occ_v && occ.mreq && memq.size() > 0 && memq[0].tag == occ.tag);
    data    = occ_held ? occ_data : rd;
    ready   = !occ.mreq || got;
    allowin = !occ_v || (ready && ws);
    check_eq("ms_allowin", bus.ms_allowin, allowin);
    check_eq("ms2ws_valid", bus.ms2ws_valid, occ_v && ready);
    check_eq("ms_ld_wait", ms_ld_wait, occ_v && occ.mreq && !got);
    check_eq("mem_rf_we", mem_rf_we, occ_v && occ.we);
    if (occ_v) check_eq("mem_dest", mem_dest, occ.dest);
    if (occ_v && ready) begin
      exp_res = occ.mreq ? ref_load(data, occ.alu[1:0], occ.op) : occ.alu;
      check_eq("final_result", final_result, exp_res);
      check_eq("ms2ws_bus", bus.ms2ws_bus, {occ.pc, occ.we, occ.dest, exp_res});
    end
    if (bus.ms2ws_valid && ws) begin
      obs_cnt++;
      obs_last = final_result;
    end
    if (ms_ld_wait) obs_wait++;
    @(posedge clk);
    if (dok && memq.size() > 0) void'(memq.pop_front());
    if (fl) begin
      occ_v = 0; occ_held = 0;
    end else if (allowin) begin
      occ_v = es_v; occ_held = 0;
      if (es_v) begin
        occ = es_ins;
        occ.tag = next_tag++;
        if (occ.mreq) memq.push_back('{occ.tag, cyc});
      end
    end else if (got && !occ_held) begin
      occ_held = 1; occ_data = rd;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    idle_in();
    bus.es2ms_valid = 0; bus.ws_allowin = 1; ms_flush = 0; data_ok = 0;
    reset = 1;
    @(posedge clk);
    #1;
    check_eq("rst_allowin", bus.ms_allowin, 1'b1);
    check_eq("rst_ms2ws_valid", bus.ms2ws_valid, 1'b0);
    check_eq("rst_rf_we", mem_rf_we, 1'b0);
    check_eq("rst_ld_wait", ms_ld_wait, 1'b0);
    @(negedge clk);
    reset = 0;
    occ_v = 0; occ_held = 0; occ.mreq = 0; memq.delete();
  endtask

  initial begin
    int stale;
    reset = 1;
    idle_in();
    occ = mk(1'b0, 3'd0, 32'h0);
    apply_reset();

    // S1: non-load passes in the cycle after entry
    clear_obs();
    idle_in(); es_v = 1; es_ins = mk(1'b0, 3'd0, 32'h12345678); step();
    idle_in(); step();
    check_eq("S1_count", obs_cnt, 1);
    check_eq("S1_result", obs_last, 32'h12345678);

    // S2: ld.b offset 3, data two cycles after entry
    clear_obs();
    idle_in(); es_v = 1; es_ins = mk(1'b1, LD_B, 32'h0000_1003); step();
    idle_in(); step();
    idle_in(); step();
    idle_in(); dok = 1; rd = 32'h80FF_0000; step();
    check_eq("S2_wait_cycles", obs_wait, 2);
    check_eq("S2_count", obs_cnt, 1);
    check_eq("S2_result", obs_last, 32'hFFFFFF80);

    // S3: ld.hu offset 2, WB stalled at data_ok, released three cycles later
    clear_obs();
    idle_in(); es_v = 1; es_ins = mk(1'b1, LD_HU, 32'h0000_2002); step();
    idle_in(); ws = 0; dok = 1; rd = 32'hBEEF_1234; step();
    idle_in(); ws = 0; step();
    idle_in(); ws = 0; step();
    idle_in(); step();
    idle_in(); step();
    check_eq("S3_count", obs_cnt, 1);
    check_eq("S3_result", obs_last, 32'h0000BEEF);

    // S4: flushed load's late return must not satisfy the next load
    clear_obs();
    idle_in(); es_v = 1; es_ins = mk(1'b1, LD_W, 32'h0000_3000); step();
    idle_in(); step();
    idle_in(); fl = 1; step();
    idle_in(); es_v = 1; es_ins = mk(1'b1, LD_W, 32'h0000_3004); step();
    idle_in(); dok = 1; rd = 32'hAAAAAAAA; step();
    idle_in(); dok = 1; rd = 32'h00000055; step();
    check_eq("S4_count", obs_cnt, 1);
    check_eq("S4_result", obs_last, 32'h00000055);

    // S5: reset mid-WAIT; next load must take the first return
    idle_in(); es_v = 1; es_ins = mk(1'b1, LD_W, 32'h0000_4000); step();
    idle_in(); step();
    apply_reset();
    clear_obs();
    idle_in(); es_v = 1; es_ins = mk(1'b1, LD_BU, 32'h0000_4001); step();
    idle_in(); dok = 1; rd = 32'h0000_C300; step();
    check_eq("S5_count", obs_cnt, 1);
    check_eq("S5_result", obs_last, 32'h000000C3);

    // S6: back-to-back loads, one result per cycle
    clear_obs();
    idle_in(); es_v = 1; es_ins = mk(1'b1, 3'($urandom), $urandom); step();
    for (int i = 0; i < 6; i++) begin
      idle_in(); es_v = 1; es_ins = mk(1'b1, 3'($urandom), $urandom); dok = 1; step();
    end
    idle_in(); dok = 1; step();
    check_eq("S6_count", obs_cnt, 7);
    check_eq("S6_wait_cycles", obs_wait, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      es_v   = ($urandom % 4) != 0;
      es_ins = mk(1'($urandom), 3'($urandom), $urandom);
      es_ins.we = 1'($urandom);
      ws     = ($urandom % 4) != 0;
      stale  = memq.size() - ((occ_v && occ.mreq && !occ_held) ? 1 : 0);
      fl     = (($urandom % 12) == 0) && (stale <= 2);
      dok    = (memq.size() > 0) && (memq[0].issued < cyc) && (($urandom % 3) != 0);
      rd     = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
